// File: rtl/wb_fwd_broadcast.sv
// Writeback broadcast: per-FU result FIFOs, up to two round-robin grants per cycle onto ROB/forwarding ports.
// Latency: push at t is broadcast at t+1 at the earliest and _dly one cycle later; an FU is stalled (ready=0) when its FIFO is full or on flush.
module wb_fwd_fifo #(
  parameter int W     = 38,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_x,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         nempty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  assign rdata  = mem[rd_ptr];
  assign full   = (count == (AW+1)'(DEPTH));
  assign nempty = (count != '0);

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end
endmodule

module wb_fwd_broadcast #(
  parameter int DATA_LEN  = 32,
  parameter int PRF_SEL   = 6,
  parameter int BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset_x,
  input  logic                flush,
  input  logic                fu0_valid,
  output logic                fu0_ready,
  input  logic [PRF_SEL-1:0]  fu0_ent,
  input  logic [DATA_LEN-1:0] fu0_data,
  input  logic                fu1_valid,
  output logic                fu1_ready,
  input  logic [PRF_SEL-1:0]  fu1_ent,
  input  logic [DATA_LEN-1:0] fu1_data,
  input  logic                fu2_valid,
  output logic                fu2_ready,
  input  logic [PRF_SEL-1:0]  fu2_ent,
  input  logic [DATA_LEN-1:0] fu2_data,
  output logic                robwe1,
  output logic                robwe2,
  output logic [PRF_SEL-1:0]  fwdrobent1,
  output logic [PRF_SEL-1:0]  fwdrobent2,
  output logic [DATA_LEN-1:0] fwdrobdata1,
  output logic [DATA_LEN-1:0] fwdrobdata2,
  output logic                robwe1_dly,
  output logic                robwe2_dly,
  output logic [PRF_SEL-1:0]  fwdrobent1_dly,
  output logic [PRF_SEL-1:0]  fwdrobent2_dly,
  output logic [DATA_LEN-1:0] fwdrobdata1_dly,
  output logic [DATA_LEN-1:0] fwdrobdata2_dly
);
  typedef struct packed {
    logic [PRF_SEL-1:0]  ent;
    logic [DATA_LEN-1:0] data;
  } res_t;

  function automatic logic [1:0] wrap3(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? (s[1:0] - 2'd3) : s[1:0];
  endfunction

  res_t       wr_res [3];
  res_t       head   [3];
  logic [2:0] fu_valid;
  logic [2:0] full;
  logic [2:0] nempty;
  logic [2:0] ready;
  logic [2:0] push;
  logic [2:0] pop;
  logic [1:0] rr;
  logic [1:0] scan_idx;
  logic       g1_vld;
  logic       g2_vld;
  logic [1:0] g1;
  logic [1:0] g2;

  always_comb begin
    wr_res[0] = '{ent: fu0_ent, data: fu0_data};
    wr_res[1] = '{ent: fu1_ent, data: fu1_data};
    wr_res[2] = '{ent: fu2_ent, data: fu2_data};
  end

  assign fu_valid  = {fu2_valid, fu1_valid, fu0_valid};
  // No same-cycle pop credit: a full FIFO stalls its FU even while it is being drained.
  assign ready     = ~full & {3{~flush}};
  assign push      = fu_valid & ready;
  assign fu0_ready = ready[0];
  assign fu1_ready = ready[1];
  assign fu2_ready = ready[2];

  for (genvar n = 0; n < 3; n++) begin : g_fu
    wb_fwd_fifo #(
      .W     ($bits(res_t)),
      .DEPTH (BUF_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset_x (reset_x),
      .flush   (flush),
      .push    (push[n]),
      .pop     (pop[n]),
      .wdata   (wr_res[n]),
      .rdata   (head[n]),
      .full    (full[n]),
      .nempty  (nempty[n])
    );
  end

  always_comb begin
    g1_vld   = 1'b0;
    g2_vld   = 1'b0;
    g1       = 2'd0;
    g2       = 2'd0;
    scan_idx = 2'd0;
    for (int k = 0; k < 3; k++) begin
      scan_idx = wrap3(rr, 2'(k));
      if (nempty[scan_idx] && !flush) begin
        if (!g1_vld) begin
          g1_vld = 1'b1;
          g1     = scan_idx;
        end else if (!g2_vld) begin
          g2_vld = 1'b1;
          g2     = scan_idx;
        end
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int n = 0; n < 3; n++) begin
      pop[n] = (g1_vld && (g1 == 2'(n))) || (g2_vld && (g2 == 2'(n)));
    end
  end

  assign robwe1      = g1_vld;
  assign robwe2      = g2_vld;
  assign fwdrobent1  = g1_vld ? head[g1].ent  : '0;
  assign fwdrobdata1 = g1_vld ? head[g1].data : '0;
  assign fwdrobent2  = g2_vld ? head[g2].ent  : '0;
  assign fwdrobdata2 = g2_vld ? head[g2].data : '0;

  // Priority restarts just past the last FU served this cycle.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      rr <= 2'd0;
    end else if (flush) begin
      rr <= 2'd0;
    end else if (g2_vld) begin
      rr <= wrap3(g2, 2'd1);
    end else if (g1_vld) begin
      rr <= wrap3(g1, 2'd1);
    end
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      robwe1_dly      <= 1'b0;
      robwe2_dly      <= 1'b0;
      fwdrobent1_dly  <= '0;
      fwdrobent2_dly  <= '0;
      fwdrobdata1_dly <= '0;
      fwdrobdata2_dly <= '0;
    end else begin
      robwe1_dly      <= robwe1;
      robwe2_dly      <= robwe2;
      fwdrobent1_dly  <= fwdrobent1;
      fwdrobent2_dly  <= fwdrobent2;
      fwdrobdata1_dly <= fwdrobdata1;
      fwdrobdata2_dly <= fwdrobdata2;
    end
  end

`ifndef SYNTHESIS
  dup_tag_a: assert property (@(posedge clk) disable iff (!reset_x)
    !(robwe1 && robwe2 && (fwdrobent1 == fwdrobent2)));
`endif
endmodule
